// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the instruction fetch unit and its
// prefetch buffer.
//   fetch_state_t : fetch sequencer states (BOOT, FETCH, DRAIN)
//   FETCH_DEPTH   : prefetch buffer depth, which is also the fetch credit limit
//   FETCH_CNT_W   : width of an occupancy count in the range 0..FETCH_DEPTH
//   fetch_entry_t : one fetched instruction tagged with its address
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   localparam int FETCH_DEPTH = 2;
   localparam int FETCH_CNT_W = $clog2(FETCH_DEPTH + 1);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: FETCH_DEPTH-entry FIFO of fetch_entry_t that sits between
// instruction memory responses and decode.
//   clk, rst   : clock and asynchronous active-high reset
//   push       : write push_entry at the tail (ignored when full without a pop)
//   push_entry : entry to write
//   pop        : remove the head entry (ignored when empty)
//   flush      : discard all entries; wins over push and pop in the same cycle
//   head       : current head entry (contents undefined when empty)
//   full/empty : occupancy flags
module fetch_buffer
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   input  logic         flush,
   output fetch_entry_t head,
   output logic         full,
   output logic         empty
);

   localparam int PTR_W = $clog2(FETCH_DEPTH);

   fetch_entry_t           mem [FETCH_DEPTH];
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W-1:0]       wr_ptr;
   logic [FETCH_CNT_W-1:0] count;
   logic                   do_push;
   logic                   do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FETCH_CNT_W'(FETCH_DEPTH));
   assign do_pop  = pop && !empty && !flush;
   // A push into a full buffer is legal when the head leaves in the same cycle;
   // the written slot is the one being vacated.
   assign do_push = push && !flush && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   // Pointers wrap naturally because FETCH_DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + FETCH_CNT_W'(do_push) - FETCH_CNT_W'(do_pop);
      end
   end

   // NOTE: the storage array has no reset; validity is tracked by count and
   // the top masks the head while empty, so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with redirect support.
// Issues word-aligned requests to instruction memory under a credit limit of
// FETCH_DEPTH (requests in flight plus buffered instructions), tags in-order
// responses with their PC, and hands them to decode through fetch_buffer.
// A redirect flushes the buffer, retargets the fetch PC and discards every
// response still owed by memory before fetching resumes.
//   clk, rst                         : clock, asynchronous active-high reset
//   redirect_valid, redirect_pc      : taken branch/jump pulse and target
//   imem_req_valid/addr/ready        : instruction memory request handshake
//   imem_rsp_valid, imem_rsp_data    : in-order memory response, no backpressure
//   inst_valid, inst_pc, inst_data   : head instruction offered to decode
//   inst_ready                       : decode consumes the head entry
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);

   fetch_state_t state;
   fetch_state_t state_next;
   logic [31:0]  fetch_pc;
   logic [1:0]   outstanding;
   logic [1:0]   drop_cnt;
   logic [1:0]   out_after;
   logic [1:0]   buffered;
   logic [2:0]   in_use;
   logic         credit_ok;
   logic         req_acc;
   logic         rsp_eff;
   logic         push;
   logic         pop;
   logic         buf_full;
   logic         buf_empty;
   fetch_entry_t push_entry;
   fetch_entry_t head;

   // Buffer occupancy recovered from its flags (depth 2: 0, 1 or 2 entries).
   assign buffered  = {buf_full, !buf_full && !buf_empty};
   assign in_use    = {1'b0, outstanding} + {1'b0, buffered};
   assign credit_ok = (in_use < 3'(FETCH_DEPTH));

   assign req_acc   = imem_req_valid && imem_req_ready;
   // A response with nothing in flight belongs to a request abandoned by reset.
   assign rsp_eff   = imem_rsp_valid && (outstanding != 2'd0);
   assign out_after = outstanding + {1'b0, req_acc} - {1'b0, rsp_eff};

   // In-flight requests are consecutive words ending just below fetch_pc
   // (a redirect only retargets after all older requests are dropped), so the
   // oldest one, which this response answers, sits outstanding words back.
   assign push_entry.pc   = fetch_pc - {28'd0, outstanding, 2'b00};
   assign push_entry.inst = imem_rsp_data;
   assign push = rsp_eff && (drop_cnt == 2'd0) && !redirect_valid;
   assign pop  = inst_valid && inst_ready;

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_next     = state;
      imem_req_valid = 1'b0;
      case (state)
         BOOT:  state_next = FETCH;
         FETCH: imem_req_valid = credit_ok;
         DRAIN: if (rsp_eff && drop_cnt == 2'd1) state_next = FETCH;
         default: state_next = BOOT;
      endcase
      // Everything still in flight after this cycle must be discarded.
      if (redirect_valid) state_next = (out_after != 2'd0) ? DRAIN : FETCH;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= BOOT;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         outstanding <= 2'd0;
         drop_cnt    <= 2'd0;
      end else begin
         outstanding <= out_after;
         if (redirect_valid) begin
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            drop_cnt <= out_after;
         end else begin
            // Wraps from 32'hFFFF_FFFC to 0 by plain modular addition.
            if (req_acc) fetch_pc <= fetch_pc + 32'd4;
            if (rsp_eff && drop_cnt != 2'd0) drop_cnt <= drop_cnt - 2'd1;
         end
      end
   end

   assign imem_req_addr = fetch_pc;

   fetch_buffer u_buffer (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (redirect_valid),
      .head       (head),
      .full       (buf_full),
      .empty      (buf_empty)
   );

   assign inst_valid = !buf_empty;
   assign inst_pc    = buf_empty ? 32'd0 : head.pc;
   assign inst_data  = buf_empty ? 32'd0 : head.inst;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// Memory responses are driven by hand, one cycle per step. Inputs change at
// posedge+1 and outputs are checked at posedge+2. A second instance with
// RESET_PC = 32'hFFFF_FFFC, memory always ready and no responses, exercises
// the fetch address wrap.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'd0;
   logic        inst_ready = 1'b0;

   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   logic        w_req_valid;
   logic [31:0] w_req_addr;
   logic        w_inst_valid;
   logic [31:0] w_inst_data;
   logic [31:0] w_inst_pc;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (1'b0),
      .redirect_pc    (32'd0),
      .imem_req_valid (w_req_valid),
      .imem_req_addr  (w_req_addr),
      .imem_req_ready (1'b1),
      .imem_rsp_valid (1'b0),
      .imem_rsp_data  (32'd0),
      .inst_valid     (w_inst_valid),
      .inst_data      (w_inst_data),
      .inst_pc        (w_inst_pc),
      .inst_ready     (1'b0)
   );

   // Instruction word the bench's memory returns for an address.
   function automatic logic [31:0] dat(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance to one time unit after the next rising edge.
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // Reset for one edge with idle inputs; returns in the BOOT cycle.
   task automatic do_reset();
      imem_rsp_valid = 1'b0;
      redirect_valid = 1'b0;
      imem_req_ready = 1'b0;
      inst_ready     = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      // ---- reset values, before any clock edge ----
      #1;
      rst = 1'b1;
      #1;
      check("rst_inst_valid", inst_valid, 32'd0);
      check("rst_req_valid", imem_req_valid, 32'd0);
      check("rst_req_addr", imem_req_addr, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
      check("rst_inst_data", inst_data, 32'd0);
      check("w_rst_req_addr", w_req_addr, 32'hFFFF_FFFC);
      check("w_rst_inst", {w_inst_valid, w_inst_pc[30:0] | w_inst_data[30:0]}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // ---- boot: sequential fetch with 1-cycle memory ----
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      #1;
      check("boot_req_valid", imem_req_valid, 32'd0);
      check("w_boot_req_valid", w_req_valid, 32'd0);
      nxt(); #1;
      check("boot_req0_valid", imem_req_valid, 32'd1);
      check("boot_req0_addr", imem_req_addr, 32'h0);
      check("w_req0_addr", w_req_addr, 32'hFFFF_FFFC);
      nxt(); imem_rsp_valid = 1'b1; imem_rsp_data = dat(32'h0); #1;
      check("boot_req1_addr", imem_req_addr, 32'h4);
      check("boot_req1_valid", imem_req_valid, 32'd1);
      check("boot_no_inst_yet", inst_valid, 32'd0);
      check("w_req1_addr_wrap", w_req_addr, 32'h0);
      nxt(); imem_rsp_data = dat(32'h4); #1;
      check("boot_inst0_pc", inst_pc, 32'h0);
      check("boot_inst0_data", inst_data, dat(32'h0));
      check("boot_credit_stall", imem_req_valid, 32'd0);
      check("w_credit_stall", w_req_valid, 32'd0);
      nxt(); imem_rsp_valid = 1'b0; #1;
      check("boot_inst1_pc", inst_pc, 32'h4);
      check("boot_inst1_data", inst_data, dat(32'h4));
      check("boot_req2_addr", imem_req_addr, 32'h8);
      nxt(); imem_rsp_valid = 1'b1; imem_rsp_data = dat(32'h8); imem_req_ready = 1'b0; #1;
      check("boot_req3_addr", imem_req_addr, 32'hC);
      check("boot_empty_between", inst_valid, 32'd0);
      nxt(); imem_rsp_valid = 1'b0; #1;
      check("boot_inst2_pc", inst_pc, 32'h8);
      check("boot_inst2_data", inst_data, dat(32'h8));
      check("boot_req3_held", {imem_req_valid, imem_req_addr[30:0]}, {1'b1, 31'hC});

      // ---- backpressure: decode stalled ----
      do_reset();
      imem_req_ready = 1'b1;
      nxt(); #1;
      check("bp_req0_addr", imem_req_addr, 32'h0);
      nxt(); imem_rsp_valid = 1'b1; imem_rsp_data = dat(32'h0); #1;
      check("bp_req1_addr", imem_req_addr, 32'h4);
      nxt(); imem_rsp_data = dat(32'h4); #1;
      check("bp_no_req_a", imem_req_valid, 32'd0);
      nxt(); imem_rsp_valid = 1'b0; #1;
      check("bp_no_req_b", imem_req_valid, 32'd0);
      check("bp_head_pc", inst_pc, 32'h0);
      nxt(); #1;
      check("bp_no_req_c", imem_req_valid, 32'd0);
      inst_ready = 1'b1;
      nxt(); inst_ready = 1'b0; #1;
      check("bp_resume_valid", imem_req_valid, 32'd1);
      check("bp_resume_addr", imem_req_addr, 32'h8);
      check("bp_head_after_pop", inst_pc, 32'h4);

      // ---- redirect with two requests outstanding ----
      do_reset();
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      nxt(); #1;
      nxt(); #1;
      check("rd_req1_addr", imem_req_addr, 32'h4);
      nxt(); redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
      check("rd_credit_full", imem_req_valid, 32'd0);
      nxt(); redirect_valid = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = dat(32'h0); #1;
      check("rd_drain_a_req", imem_req_valid, 32'd0);
      nxt(); imem_rsp_data = dat(32'h4); #1;
      check("rd_drain_b_req", imem_req_valid, 32'd0);
      check("rd_drop_a", inst_valid, 32'd0);
      nxt(); imem_rsp_valid = 1'b0; #1;
      check("rd_drop_b", inst_valid, 32'd0);
      check("rd_target_valid", imem_req_valid, 32'd1);
      check("rd_target_addr", imem_req_addr, 32'h100);
      nxt(); imem_rsp_valid = 1'b1; imem_rsp_data = dat(32'h100); #1;
      check("rd_next_addr", imem_req_addr, 32'h104);
      nxt(); imem_rsp_valid = 1'b0; imem_req_ready = 1'b0; #1;
      check("rd_first_pc", inst_pc, 32'h100);
      check("rd_first_data", inst_data, dat(32'h100));

      // ---- redirect coinciding with a response and an accepted request ----
      do_reset();
      imem_req_ready = 1'b1;
      nxt(); #1;
      check("rs_req0_addr", imem_req_addr, 32'h0);
      nxt(); imem_rsp_valid = 1'b1; imem_rsp_data = dat(32'h0);
      redirect_valid = 1'b1; redirect_pc = 32'h203; #1;
      check("rs_req_same_cycle", imem_req_addr, 32'h4);
      nxt(); imem_rsp_valid = 1'b0; redirect_valid = 1'b0; #1;
      check("rs_rsp_dropped", inst_valid, 32'd0);
      check("rs_drain_req", imem_req_valid, 32'd0);
      nxt(); imem_rsp_valid = 1'b1; imem_rsp_data = dat(32'h4); #1;
      check("rs_drain_req_b", imem_req_valid, 32'd0);
      nxt(); imem_rsp_valid = 1'b0; #1;
      check("rs_aligned_addr", imem_req_addr, 32'h200);
      check("rs_aligned_valid", imem_req_valid, 32'd1);
      check("rs_still_empty", inst_valid, 32'd0);
      nxt(); imem_rsp_valid = 1'b1; imem_rsp_data = dat(32'h200); #1;
      check("rs_next_addr", imem_req_addr, 32'h204);
      nxt(); imem_rsp_data = dat(32'h204); #1;
      check("rs_head_pc", inst_pc, 32'h200);
      check("rs_no_req", imem_req_valid, 32'd0);
      // Redirect with a full buffer and a dequeue in the same cycle.
      nxt(); imem_rsp_valid = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
      inst_ready = 1'b1; #1;
      check("fl_head_before", inst_pc, 32'h200);
      nxt(); redirect_valid = 1'b0; inst_ready = 1'b0; #1;
      check("fl_flushed", inst_valid, 32'd0);
      check("fl_fetch_valid", imem_req_valid, 32'd1);
      check("fl_fetch_addr", imem_req_addr, 32'h300);

      // ---- reset while draining ----
      do_reset();
      imem_req_ready = 1'b1;
      inst_ready     = 1'b1;
      nxt(); #1;
      nxt(); #1;
      nxt(); redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
      nxt(); redirect_valid = 1'b0; #1;
      check("md_draining", imem_req_valid, 32'd0);
      rst = 1'b1;
      #1;
      check("md_rst_inst_valid", inst_valid, 32'd0);
      check("md_rst_req_valid", imem_req_valid, 32'd0);
      check("md_rst_req_addr", imem_req_addr, 32'h0);
      check("md_rst_inst_pc", inst_pc, 32'd0);
      check("md_rst_inst_data", inst_data, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      // A late response for an abandoned request must be ignored.
      imem_rsp_valid = 1'b1; imem_rsp_data = dat(32'h0); #1;
      check("md_boot_req", imem_req_valid, 32'd0);
      nxt(); imem_rsp_valid = 1'b0; #1;
      check("md_stale_ignored", inst_valid, 32'd0);
      check("md_restart_valid", imem_req_valid, 32'd1);
      check("md_restart_addr", imem_req_addr, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
